// File: rtl/intellitec_shed_scheduler.sv
// Two-zone compressor power-budget scheduler: anti-short-cycle lockout,
// staggered grants, preemption on budget cut and round-robin sharing.
module intellitec_shed_scheduler #(
   parameter int TICK_DIV = 1000,
   parameter int TW       = 8,
   parameter int MIN_OFF  = 120,
   parameter int MIN_RUN  = 60,
   parameter int STAGGER  = 10
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] ac_req,
   input  logic [1:0] max_units,
   output logic [1:0] shed,
   output logic [1:0] running,
   output logic       tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] LOCK  = 2'd0;
   localparam logic [1:0] READY = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    st_q  [2];
   logic [1:0]    st_d  [2];
   logic [TW-1:0] off_q [2];
   logic [TW-1:0] off_d [2];
   logic [TW-1:0] run_q [2];
   logic [TW-1:0] run_d [2];
   logic [TW-1:0] stag_q, stag_d;
   logic          rr_q, rr_d;
   logic          last_q, last_d;

   logic [1:0] max_eff;
   logic [1:0] run_cnt;
   logic [1:0] cand;
   logic       grant_vld;
   logic       grant_zone;
   logic [1:0] preempt;
   logic [1:0] rotate;

   always_comb begin
      tick     = (presc_q == PW'(TICK_DIV - 1));
      presc_d  = tick ? '0 : presc_q + 1'b1;
      max_eff  = (max_units == 2'd3) ? 2'd2 : max_units;
      run_cnt  = {1'b0, st_q[0] == RUN} + {1'b0, st_q[1] == RUN};

      for (int i = 0; i < 2; i++) begin
         cand[i]    = (st_q[i] == READY) && ac_req[i] && (stag_q == '0) && (run_cnt < max_eff);
         // The latest grant is shed first when the budget shrinks below the running count.
         preempt[i] = (st_q[i] == RUN) && (run_cnt > max_eff) &&
                      ((max_eff == 2'd0) || (last_q == i[0]));
         rotate[i]  = (st_q[i] == RUN) && (max_eff == 2'd1) && (st_q[1-i] == READY) &&
                      ac_req[1-i] && (run_q[i] >= TW'(MIN_RUN));
      end

      grant_vld  = |cand;
      grant_zone = (&cand) ? rr_q : cand[1];

      stag_d = stag_q;
      rr_d   = rr_q;
      last_d = last_q;
      if (grant_vld) begin
         stag_d = TW'(STAGGER);
         rr_d   = ~grant_zone;
         last_d = grant_zone;
      end else if (tick && stag_q != '0) begin
         stag_d = stag_q - 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
         st_d[i]  = st_q[i];
         off_d[i] = (tick && off_q[i] != '0) ? off_q[i] - 1'b1 : off_q[i];
         run_d[i] = (tick && run_q[i] != '1) ? run_q[i] + 1'b1 : run_q[i];
         case (st_q[i])
            LOCK: begin
               if (tick && off_q[i] <= TW'(1)) st_d[i] = READY;
            end
            READY: begin
               if (grant_vld && grant_zone == i[0]) begin
                  st_d[i]  = RUN;
                  run_d[i] = '0;
               end
            end
            RUN: begin
               if (!ac_req[i] || preempt[i] || rotate[i]) begin
                  st_d[i]  = LOCK;
                  off_d[i] = TW'(MIN_OFF);
               end
            end
            default: st_d[i] = LOCK;
         endcase
         running[i] = (st_q[i] == RUN);
         shed[i]    = (st_q[i] != RUN);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         stag_q  <= '0;
         rr_q    <= 1'b0;
         last_q  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= LOCK;
            off_q[i] <= TW'(MIN_OFF);
            run_q[i] <= '0;
         end
      end else begin
         presc_q <= presc_d;
         stag_q  <= stag_d;
         rr_q    <= rr_d;
         last_q  <= last_d;
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= st_d[i];
            off_q[i] <= off_d[i];
            run_q[i] <= run_d[i];
         end
      end
   end

endmodule

// File: tb/tb_intellitec_shed_scheduler.sv
// Directed bench for the two-zone shed scheduler with short timers.
module tb_intellitec_shed_scheduler;

   logic       clock;
   logic       reset_n;
   logic [1:0] ac_req;
   logic [1:0] max_units;
   logic [1:0] shed;
   logic [1:0] running;
   logic       tick;

   int errors = 0;
   int checks = 0;
   int cur    = 0;

   intellitec_shed_scheduler #(
      .TICK_DIV (4),
      .TW       (8),
      .MIN_OFF  (3),
      .MIN_RUN  (5),
      .STAGGER  (2)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .ac_req    (ac_req),
      .max_units (max_units),
      .shed      (shed),
      .running   (running),
      .tick      (tick)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic do_reset(input logic [1:0] ac, input logic [1:0] mx);
      reset_n   = 1'b0;
      ac_req    = ac;
      max_units = mx;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      cur     = 0;
   endtask

   // Advance to 1 time unit after rising edge k (counted from reset release).
   task automatic adv(input int k);
      while (cur < k) begin
         @(posedge clock);
         cur++;
      end
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; ac_req = 2'b00; max_units = 2'd2;
      @(negedge clock);
      checks++; if (shed !== 2'b11) begin errors++; $display("FAIL reset_shed: got %b expected 11", shed); end
      checks++; if (running !== 2'b00) begin errors++; $display("FAIL reset_running: got %b expected 00", running); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
   endtask

   task automatic test_lockout;
      do_reset(2'b01, 2'd2);
      adv(3);
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL tick_e3: got %b expected 1", tick); end
      adv(4);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_e4: got %b expected 0", tick); end
      adv(12);
      checks++; if (shed !== 2'b11) begin errors++; $display("FAIL lockout_e12: got %b expected 11", shed); end
      adv(13);
      checks++; if (shed !== 2'b10) begin errors++; $display("FAIL lockout_e13_shed: got %b expected 10", shed); end
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL lockout_e13_run: got %b expected 01", running); end
   endtask

   task automatic test_stagger_and_drop;
      do_reset(2'b11, 2'd2);
      adv(13);
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL stagger_e13: got %b expected 01", running); end
      adv(20);
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL stagger_e20: got %b expected 01", running); end
      adv(21);
      checks++; if (shed !== 2'b00) begin errors++; $display("FAIL stagger_e21: got %b expected 00", shed); end
      adv(22);
      ac_req = 2'b10;
      adv(23);
      ac_req = 2'b11;
      checks++; if (shed !== 2'b01) begin errors++; $display("FAIL drop_e23: got %b expected 01", shed); end
      adv(32);
      checks++; if (running !== 2'b10) begin errors++; $display("FAIL drop_e32: got %b expected 10", running); end
      adv(33);
      checks++; if (running !== 2'b11) begin errors++; $display("FAIL drop_e33: got %b expected 11", running); end
   endtask

   task automatic test_preempt;
      do_reset(2'b11, 2'd2);
      adv(22);
      max_units = 2'd3;
      adv(23);
      checks++; if (running !== 2'b11) begin errors++; $display("FAIL max3_as_2: got %b expected 11", running); end
      max_units = 2'd1;
      adv(24);
      checks++; if (shed !== 2'b10) begin errors++; $display("FAIL preempt_shed: got %b expected 10", shed); end
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL preempt_run: got %b expected 01", running); end
      do_reset(2'b11, 2'd2);
      adv(22);
      max_units = 2'd0;
      adv(23);
      checks++; if (shed !== 2'b11) begin errors++; $display("FAIL preempt_max0: got %b expected 11", shed); end
   endtask

   task automatic test_rotation;
      do_reset(2'b11, 2'd1);
      adv(20);
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL rot_e20: got %b expected 01", running); end
      adv(32);
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL rot_e32: got %b expected 01", running); end
      adv(33);
      checks++; if (running !== 2'b00) begin errors++; $display("FAIL rot_e33: got %b expected 00", running); end
      adv(34);
      checks++; if (running !== 2'b10) begin errors++; $display("FAIL rot_e34: got %b expected 10", running); end
      adv(52);
      checks++; if (running !== 2'b10) begin errors++; $display("FAIL rot_e52: got %b expected 10", running); end
      adv(53);
      checks++; if (running !== 2'b00) begin errors++; $display("FAIL rot_e53: got %b expected 00", running); end
      adv(54);
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL rot_e54: got %b expected 01", running); end
   endtask

   task automatic test_async_reset;
      do_reset(2'b01, 2'd2);
      adv(13);
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL arst_pre: got %b expected 01", running); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (shed !== 2'b11) begin errors++; $display("FAIL arst_shed: got %b expected 11", shed); end
      checks++; if (running !== 2'b00) begin errors++; $display("FAIL arst_run: got %b expected 00", running); end
      @(negedge clock);
      reset_n = 1'b1;
      cur     = 0;
      adv(12);
      checks++; if (shed !== 2'b11) begin errors++; $display("FAIL arst_e12: got %b expected 11", shed); end
      adv(13);
      checks++; if (running !== 2'b01) begin errors++; $display("FAIL arst_e13: got %b expected 01", running); end
   endtask

   initial begin
      reset_n   = 1'b1;
      ac_req    = 2'b00;
      max_units = 2'd0;
      #2;
      test_reset();
      test_lockout();
      test_stagger_and_drop();
      test_preempt();
      test_rotation();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
